// File: rtl/cac_frame_if.sv
// Byte-in / frame-out bundle between the CAC UART receiver, the frame parser and its consumer.
interface cac_frame_if #(
   parameter int unsigned MAX_PAYLOAD = 16
);
   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic [7:0]               frm_cmd;
   logic [4:0]               frm_len;
   logic [MAX_PAYLOAD*8-1:0] frm_payload;
   logic                     frm_valid;
   logic                     frm_ready;
   logic                     err_checksum;
   logic                     err_length;
   logic                     err_timeout;
   logic                     err_overrun;

   // Byte source and frame consumer side
   modport master (
      output rx_data, rx_valid, frm_ready,
      input  frm_cmd, frm_len, frm_payload, frm_valid,
      input  err_checksum, err_length, err_timeout, err_overrun
   );

   // Parser side
   modport slave (
      input  rx_data, rx_valid, frm_ready,
      output frm_cmd, frm_len, frm_payload, frm_valid,
      output err_checksum, err_length, err_timeout, err_overrun
   );
endinterface

// File: rtl/cac_frame_parser.sv
// Parses SOF/CMD/LEN/payload/CHK byte frames and holds each good frame until consumed.
// Optional inter-byte timeout is compiled in with `define CAC_FRAME_TIMEOUT_EN.
module cac_frame_parser #(
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned MAX_PAYLOAD    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input logic        clk,
   input logic        rst,
   cac_frame_if.slave bus
);

   localparam int unsigned PW = MAX_PAYLOAD * 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CHECK   = 3'd4;
   localparam logic [2:0] S_HOLD    = 3'd5;

   logic [2:0]                  state_q, state_d;
   logic [7:0]                  xor_q, xor_d;
   logic [4:0]                  cnt_q, cnt_d;
   logic [7:0]                  cmd_q, cmd_d;
   logic [4:0]                  len_q, len_d;
   logic [MAX_PAYLOAD-1:0][7:0] buf_q, buf_d;

   logic [7:0]                  frm_cmd_q, frm_cmd_d;
   logic [4:0]                  frm_len_q, frm_len_d;
   logic [PW-1:0]               frm_payload_q, frm_payload_d;
   logic                        frm_valid_q, frm_valid_d;
   logic                        err_checksum_q, err_checksum_d;
   logic                        err_length_q, err_length_d;
   logic                        err_overrun_q, err_overrun_d;

`ifdef CAC_FRAME_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_timeout_q, err_timeout_d;
`endif

   // Next-state and datapath
   always_comb begin
      state_d        = state_q;
      xor_d          = xor_q;
      cnt_d          = cnt_q;
      cmd_d          = cmd_q;
      len_d          = len_q;
      buf_d          = buf_q;
      frm_cmd_d      = frm_cmd_q;
      frm_len_d      = frm_len_q;
      frm_payload_d  = frm_payload_q;
      frm_valid_d    = frm_valid_q;
      err_checksum_d = 1'b0;
      err_length_d   = 1'b0;
      err_overrun_d  = 1'b0;
`ifdef CAC_FRAME_TIMEOUT_EN
      tmo_d          = tmo_q;
      err_timeout_d  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            // Clearing the work buffer here keeps bytes beyond LEN at zero
            if (bus.rx_valid && bus.rx_data == SOF_BYTE) begin
               state_d = S_CMD;
               buf_d   = '0;
               cnt_d   = 5'd0;
               xor_d   = 8'h00;
            end
         end
         S_CMD: begin
            if (bus.rx_valid) begin
               cmd_d   = bus.rx_data;
               xor_d   = bus.rx_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (bus.rx_valid) begin
               xor_d = xor_q ^ bus.rx_data;
               if (bus.rx_data > 8'(MAX_PAYLOAD)) begin
                  err_length_d = 1'b1;
                  state_d      = S_IDLE;
               end else if (bus.rx_data == 8'h00) begin
                  len_d   = 5'd0;
                  state_d = S_CHECK;
               end else begin
                  len_d   = 5'(bus.rx_data);
                  cnt_d   = 5'd0;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (bus.rx_valid) begin
               for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                  if (cnt_q == 5'(i)) buf_d[i] = bus.rx_data;
               end
               xor_d = xor_q ^ bus.rx_data;
               if (cnt_q == len_q - 5'd1) state_d = S_CHECK;
               else                       cnt_d   = cnt_q + 5'd1;
            end
         end
         S_CHECK: begin
            if (bus.rx_valid) begin
               if (bus.rx_data == xor_q) begin
                  frm_cmd_d     = cmd_q;
                  frm_len_d     = len_q;
                  frm_payload_d = buf_q;
                  frm_valid_d   = 1'b1;
                  state_d       = S_HOLD;
               end else begin
                  err_checksum_d = 1'b1;
                  state_d        = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            // Bytes arriving while a frame is held are dropped
            if (bus.rx_valid) err_overrun_d = 1'b1;
            if (frm_valid_q && bus.frm_ready) begin
               frm_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef CAC_FRAME_TIMEOUT_EN
      // Inter-byte silence counter, live only while a frame is partially received
      if (state_q == S_CMD || state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHECK) begin
         if (bus.rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d         = '0;
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         tmo_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         xor_q          <= 8'h00;
         cnt_q          <= 5'd0;
         cmd_q          <= 8'h00;
         len_q          <= 5'd0;
         buf_q          <= '0;
         frm_cmd_q      <= 8'h00;
         frm_len_q      <= 5'd0;
         frm_payload_q  <= '0;
         frm_valid_q    <= 1'b0;
         err_checksum_q <= 1'b0;
         err_length_q   <= 1'b0;
         err_overrun_q  <= 1'b0;
`ifdef CAC_FRAME_TIMEOUT_EN
         tmo_q          <= '0;
         err_timeout_q  <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         xor_q          <= xor_d;
         cnt_q          <= cnt_d;
         cmd_q          <= cmd_d;
         len_q          <= len_d;
         buf_q          <= buf_d;
         frm_cmd_q      <= frm_cmd_d;
         frm_len_q      <= frm_len_d;
         frm_payload_q  <= frm_payload_d;
         frm_valid_q    <= frm_valid_d;
         err_checksum_q <= err_checksum_d;
         err_length_q   <= err_length_d;
         err_overrun_q  <= err_overrun_d;
`ifdef CAC_FRAME_TIMEOUT_EN
         tmo_q          <= tmo_d;
         err_timeout_q  <= err_timeout_d;
`endif
      end
   end

   assign bus.frm_cmd      = frm_cmd_q;
   assign bus.frm_len      = frm_len_q;
   assign bus.frm_payload  = frm_payload_q;
   assign bus.frm_valid    = frm_valid_q;
   assign bus.err_checksum = err_checksum_q;
   assign bus.err_length   = err_length_q;
   assign bus.err_overrun  = err_overrun_q;
`ifdef CAC_FRAME_TIMEOUT_EN
   assign bus.err_timeout  = err_timeout_q;
`else
   assign bus.err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_cac_frame_parser.sv
// Scoreboard bench for cac_frame_parser: drivers queue expected frames/pulses, a negedge monitor checks them.
module tb_cac_frame_parser;

   localparam int unsigned MAX_PAYLOAD = 16;
   localparam int unsigned PW          = MAX_PAYLOAD * 8;
`ifdef CAC_FRAME_TIMEOUT_EN
   localparam int unsigned TMO = 50;
`else
   localparam int unsigned TMO = 100000;
`endif

   localparam int K_ERR   = 0;
   localparam int K_FRAME = 1;
   localparam int K_DROP  = 2;

   localparam logic [3:0] E_CHK = 4'b1000;
   localparam logic [3:0] E_LEN = 4'b0100;
   localparam logic [3:0] E_TMO = 4'b0010;
   localparam logic [3:0] E_OVR = 4'b0001;

   typedef struct {
      int            kind;
      logic [3:0]    errs;
      logic [7:0]    cmd;
      logic [4:0]    len;
      logic [PW-1:0] pl;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   tmo_seen = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cac_frame_if #(.MAX_PAYLOAD(MAX_PAYLOAD)) bus ();

   cac_frame_parser #(
      .SOF_BYTE      (8'hA5),
      .MAX_PAYLOAD   (MAX_PAYLOAD),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at cyc %0d", name, got, exp, cyc);
      end
   endtask

   // Monitor: pop the scoreboard whenever the DUT presents a pulse, a new frame or a frame drop
   logic prev_valid = 1'b0;
   exp_t held;
   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] errs;
      errs = {bus.err_checksum, bus.err_length, bus.err_timeout, bus.err_overrun};
      if (bus.err_timeout === 1'b1) tmo_seen++;
      if (errs != 4'b0000) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL err_unexpected got=%b at cyc %0d", errs, cyc);
         end else begin
            e = sb.pop_front();
            if (e.kind != K_ERR || e.errs != errs || e.cyc != cyc) begin
               errors++;
               $display("FAIL err_pulse got=%b@%0d exp kind%0d %b@%0d", errs, cyc, e.kind, e.errs, e.cyc);
            end
         end
      end
      if (bus.frm_valid === 1'b1 && !prev_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected got cmd=%h len=%0d at cyc %0d", bus.frm_cmd, bus.frm_len, cyc);
         end else begin
            e = sb.pop_front();
            held = e;
            if (e.kind != K_FRAME || e.cmd !== bus.frm_cmd || e.len !== bus.frm_len ||
                e.pl !== bus.frm_payload || e.cyc != cyc) begin
               errors++;
               $display("FAIL frame got cmd=%h len=%0d pl=%h @%0d exp kind%0d cmd=%h len=%0d pl=%h @%0d",
                        bus.frm_cmd, bus.frm_len, bus.frm_payload, cyc,
                        e.kind, e.cmd, e.len, e.pl, e.cyc);
            end
         end
      end else if (bus.frm_valid === 1'b1) begin
         checks++;
         if (held.cmd !== bus.frm_cmd || held.len !== bus.frm_len || held.pl !== bus.frm_payload) begin
            errors++;
            $display("FAIL frame_stable got cmd=%h len=%0d pl=%h exp cmd=%h len=%0d pl=%h",
                     bus.frm_cmd, bus.frm_len, bus.frm_payload, held.cmd, held.len, held.pl);
         end
      end
      if (bus.frm_valid === 1'b0 && prev_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL drop_unexpected at cyc %0d", cyc);
         end else begin
            e = sb.pop_front();
            if (e.kind != K_DROP || e.cyc != cyc) begin
               errors++;
               $display("FAIL drop got @%0d exp kind%0d @%0d", cyc, e.kind, e.cyc);
            end
         end
      end
      prev_valid = (bus.frm_valid === 1'b1);
   end

   task automatic push(input int kind, input logic [3:0] errs, input logic [7:0] cmd,
                       input logic [4:0] len, input logic [PW-1:0] pl, input int c);
      exp_t e;
      e.kind = kind; e.errs = errs; e.cmd = cmd; e.len = len; e.pl = pl; e.cyc = c;
      sb.push_back(e);
   endtask

   // One rx_valid strobe; c returns the cycle number of the sampling edge
   task automatic send(input logic [7:0] b, output int c);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      c = cyc;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input int len, input logic [PW-1:0] pl,
                             input logic [7:0] chk_mask);
      logic [7:0]    x;
      logic [7:0]    b;
      logic [PW-1:0] exp_pl;
      int            c;
      x      = cmd ^ 8'(len);
      exp_pl = '0;
      send(8'hA5, c);
      send(cmd, c);
      send(8'(len), c);
      for (int i = 0; i < len; i++) begin
         b = pl[i*8 +: 8];
         exp_pl[i*8 +: 8] = b;
         x = x ^ b;
         send(b, c);
      end
      send(x ^ chk_mask, c);
      if (chk_mask == 8'h00) push(K_FRAME, 4'b0000, cmd, 5'(len), exp_pl, c);
      else                   push(K_ERR, E_CHK, 8'h00, 5'd0, '0, c);
   endtask

   task automatic consume();
      bus.frm_ready = 1'b1;
      @(posedge clk);
      #1;
      push(K_DROP, 4'b0000, 8'h00, 5'd0, '0, cyc);
      bus.frm_ready = 1'b0;
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_valid"}, PW'(bus.frm_valid), '0);
      chk({tag, "_cmd"}, PW'(bus.frm_cmd), '0);
      chk({tag, "_len"}, PW'(bus.frm_len), '0);
      chk({tag, "_payload"}, bus.frm_payload, '0);
      chk({tag, "_errs"}, PW'({bus.err_checksum, bus.err_length, bus.err_timeout, bus.err_overrun}), '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PW-1:0] pl;
      int            c;
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.frm_ready = 1'b0;

      apply_reset("reset");

      // Non-SOF byte in IDLE is silently ignored
      send(8'h33, c);

      // Basic two-byte frame, checksum 10^02^01^02 = 11
      pl = '0; pl[15:0] = 16'h0201;
      send_frame(8'h10, 2, pl, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      consume();

      // Same frame with checksum 10 -> rejected, then the good frame again
      send_frame(8'h10, 2, pl, 8'h01);
      send_frame(8'h10, 2, pl, 8'h00);
      consume();

      // LEN 0x11 exceeds MAX_PAYLOAD
      send(8'hA5, c); send(8'h20, c); send(8'h11, c);
      push(K_ERR, E_LEN, 8'h00, 5'd0, '0, c);

      // Zero-length frame A5,20,00,20
      send_frame(8'h20, 0, '0, 8'h00);
      consume();

      // Full MAX_PAYLOAD frame
      pl = '0;
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) pl[i*8 +: 8] = 8'(i * 17 + 3);
      send_frame(8'h7E, int'(MAX_PAYLOAD), pl, 8'h00);
      consume();

      // Short frame after a long one: upper payload bytes must read 0
      pl = '0; pl[15:0] = 16'hBEEF;
      send_frame(8'h5A, 2, pl, 8'h00);
      consume();

      // Overrun while held, frame stays intact, then consumed
      pl = '0; pl[7:0] = 8'hC3;
      send_frame(8'h42, 1, pl, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      send(8'h55, c);
      push(K_ERR, E_OVR, 8'h00, 5'd0, '0, c);
      repeat (3) @(posedge clk);
      #1;
      consume();

      // rx_valid coincides with frm_ready in HOLD
      pl = '0; pl[23:0] = 24'h030201;
      send_frame(8'h99, 3, pl, 8'h00);
      bus.frm_ready = 1'b1;
      send(8'h66, c);
      bus.frm_ready = 1'b0;
      push(K_ERR, E_OVR, 8'h00, 5'd0, '0, c);
      push(K_DROP, 4'b0000, 8'h00, 5'd0, '0, c);

      // Inter-byte silence after A5,10
      send(8'hA5, c); send(8'h10, c);
`ifdef CAC_FRAME_TIMEOUT_EN
      push(K_ERR, E_TMO, 8'h00, 5'd0, '0, c + int'(TMO));
      repeat (int'(TMO) + 10) @(posedge clk);
      #1;
      chk("timeout_count", PW'(tmo_seen), PW'(1));
`else
      repeat (1000) @(posedge clk);
      #1;
      chk("no_timeout", PW'(tmo_seen), '0);
      apply_reset("idle_reset");
`endif

      // Reset mid-frame discards it silently; next frame reported correctly
      send(8'hA5, c); send(8'h10, c); send(8'h02, c); send(8'h01, c);
      apply_reset("mid_reset");
      pl = '0; pl[15:0] = 16'h0201;
      send_frame(8'h10, 2, pl, 8'h00);
      consume();

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", PW'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
